// File: rtl/fetch_unit_if.sv
// Instruction-memory and IF/ID bundle for the fetch stage.
interface fetch_unit_if #(
  parameter int WORD_W = 32
);
  logic              ihit;
  logic [WORD_W-1:0] iload;
  logic              imemREN;
  logic [WORD_W-1:0] imemaddr;
  logic              stall;
  logic              redirect;
  logic [WORD_W-1:0] redirect_pc;
  logic              halt;
  logic [WORD_W-1:0] ifid_PC4;
  logic [WORD_W-1:0] ifid_instr;
  logic              ifid_EN;
  logic              ifid_flush;

  modport master (
    input  ihit, iload, stall,
    input  redirect, redirect_pc, halt,
    output imemREN, imemaddr,
    output ifid_PC4, ifid_instr,
    output ifid_EN, ifid_flush
  );

  modport slave (
    output ihit, iload, stall,
    output redirect, redirect_pc, halt,
    input  imemREN, imemaddr,
    input  ifid_PC4, ifid_instr,
    input  ifid_EN, ifid_flush
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, buffers one word
// under stall and defers redirects until the in-flight fetch returns.
module fetch_unit #(
  parameter int              WORD_W  = 32,
  parameter logic [WORD_W-1:0] PC_INIT = '0
) (
  input  logic CLK,
  input  logic nRST,
  fetch_unit_if.master fif
);

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    HALTED
  } state_t;

  state_t            state, state_n;
  logic [WORD_W-1:0] pc, pc_n;
  logic [WORD_W-1:0] buf_q, buf_n;
  logic              pend_valid, pend_valid_n;
  logic [WORD_W-1:0] pend_pc, pend_pc_n;
  logic [WORD_W-1:0] pc4;
  logic              en;

  assign pc4 = pc + WORD_W'(4);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= FETCH;
      pc         <= PC_INIT;
      buf_q      <= '0;
      pend_valid <= 1'b0;
      pend_pc    <= '0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      buf_q      <= buf_n;
      pend_valid <= pend_valid_n;
      pend_pc    <= pend_pc_n;
    end
  end

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    buf_n        = buf_q;
    pend_valid_n = pend_valid;
    pend_pc_n    = pend_pc;
    en           = 1'b0;
    if (fif.halt) begin
      state_n      = HALTED;
      pend_valid_n = 1'b0;
    end else begin
      unique case (state)
        FETCH: begin
          // the address stays put until memory answers
          if (fif.redirect) begin
            if (fif.ihit) begin
              pc_n         = fif.redirect_pc;
              pend_valid_n = 1'b0;
            end else begin
              pend_valid_n = 1'b1;
              pend_pc_n    = fif.redirect_pc;
            end
          end else if (fif.ihit) begin
            if (pend_valid) begin
              pc_n         = pend_pc;
              pend_valid_n = 1'b0;
            end else if (fif.stall) begin
              buf_n   = fif.iload;
              state_n = HOLD;
            end else begin
              en   = 1'b1;
              pc_n = pc4;
            end
          end
        end
        HOLD: begin
          if (fif.redirect) begin
            pc_n         = fif.redirect_pc;
            pend_valid_n = 1'b0;
            state_n      = FETCH;
          end else if (!fif.stall) begin
            en      = 1'b1;
            pc_n    = pc4;
            state_n = FETCH;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign fif.imemaddr   = pc;
  assign fif.ifid_PC4   = pc4;
  assign fif.imemREN    = nRST && (state == FETCH);
  assign fif.ifid_EN    = nRST && en;
  assign fif.ifid_flush = nRST && fif.redirect
                          && !fif.halt
                          && (state != HALTED);

  always_comb begin
    unique case (state)
      FETCH:   fif.ifid_instr = fif.iload;
      HOLD:    fif.ifid_instr = buf_q;
      default: fif.ifid_instr = '0;
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: accepted words are queued
// when driven and checked when the stage raises ifid_EN.
module tb_fetch_unit;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  int   vectors = 0;
  int   errors = 0;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
  } exp_t;

  exp_t sb[$];

  fetch_unit_if #(.WORD_W(32)) m ();
  fetch_unit_if #(.WORD_W(32)) w ();

  fetch_unit #(
    .WORD_W(32), .PC_INIT(32'h0)
  ) u_dut (
    .CLK(CLK), .nRST(nRST), .fif(m.master)
  );

  fetch_unit #(
    .WORD_W(32), .PC_INIT(32'hFFFF_FFFC)
  ) u_wrap (
    .CLK(CLK), .nRST(nRST), .fif(w.master)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
  endfunction

  always_comb m.iload = word(m.imemaddr);
  always_comb w.iload = word(w.imemaddr);

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] a);
    exp_t e;
    e.pc4   = a + 32'd4;
    e.instr = word(a);
    sb.push_back(e);
  endtask

  always @(negedge CLK) begin
    if (nRST && m.ifid_EN) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_en", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_pc4", m.ifid_PC4, e.pc4);
        chk("sb_instr", m.ifid_instr, e.instr);
      end
    end
  end

  task automatic drive(input logic ih, input logic st,
                       input logic rd, input logic [31:0] rp,
                       input logic hl);
    m.ihit        = ih;
    m.stall       = st;
    m.redirect    = rd;
    m.redirect_pc = rp;
    m.halt        = hl;
  endtask

  task automatic next;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0);
    w.ihit = 1'b1; w.stall = 1'b0;
    w.redirect = 1'b0; w.redirect_pc = '0;
    w.halt = 1'b0;

    @(negedge CLK);
    chk("rst_ren", m.imemREN, 0);
    chk("rst_en", m.ifid_EN, 0);
    chk("rst_flush", m.ifid_flush, 0);
    chk("rst_addr", m.imemaddr, 0);
    next;
    nRST = 1'b1;

    // streaming 0,4 then a stall at 8
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 0, 0);
      push(i * 4);
      @(negedge CLK);
      chk("run_addr", m.imemaddr, i * 4);
      chk("run_en", m.ifid_EN, 1);
      if (i == 0) begin
        chk("wrap_addr", w.imemaddr, 32'hFFFF_FFFC);
        chk("wrap_pc4", w.ifid_PC4, 0);
        chk("wrap_en", w.ifid_EN, 1);
      end
      next;
      if (i == 0) chk("wrap_pc", w.imemaddr, 0);
    end

    drive(1, 1, 0, 0, 0);
    @(negedge CLK);
    chk("stall_addr", m.imemaddr, 8);
    chk("stall_en", m.ifid_EN, 0);
    next;
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 0, 0, 0);
      @(negedge CLK);
      chk("hold_ren", m.imemREN, 0);
      chk("hold_en", m.ifid_EN, 0);
      chk("hold_instr", m.ifid_instr, word(8));
      chk("hold_addr", m.imemaddr, 8);
      next;
    end
    drive(0, 0, 0, 0, 0);
    push(8);
    @(negedge CLK);
    chk("release_en", m.ifid_EN, 1);
    next;
    chk("release_addr", m.imemaddr, 12);
    drive(1, 0, 0, 0, 0);
    push(12);
    next;

    // redirect while fetch at 16 is in flight
    drive(0, 0, 1, 32'h100, 0);
    @(negedge CLK);
    chk("rd_flush", m.ifid_flush, 1);
    chk("rd_en", m.ifid_EN, 0);
    chk("rd_addr", m.imemaddr, 16);
    next;
    drive(0, 0, 0, 0, 0);
    @(negedge CLK);
    chk("rd_wait_addr", m.imemaddr, 16);
    next;
    drive(1, 0, 0, 0, 0);
    @(negedge CLK);
    chk("rd_discard_en", m.ifid_EN, 0);
    chk("rd_discard_addr", m.imemaddr, 16);
    next;
    chk("rd_target", m.imemaddr, 32'h100);

    // newest of two pending redirects wins
    drive(0, 0, 1, 32'h200, 0);
    next;
    drive(0, 0, 1, 32'h300, 0);
    next;
    drive(1, 0, 0, 0, 0);
    @(negedge CLK);
    chk("rd2_discard_en", m.ifid_EN, 0);
    next;
    chk("rd2_target", m.imemaddr, 32'h300);

    // redirect out of HOLD drops the buffered word
    drive(1, 1, 0, 0, 0);
    next;
    drive(0, 1, 1, 32'h40, 0);
    @(negedge CLK);
    chk("holdrd_flush", m.ifid_flush, 1);
    chk("holdrd_en", m.ifid_EN, 0);
    next;
    drive(0, 0, 0, 0, 0);
    chk("holdrd_addr", m.imemaddr, 32'h40);
    chk("holdrd_ren", m.imemREN, 1);

    // reset pulse while a redirect is pending
    drive(0, 0, 1, 32'h500, 0);
    next;
    drive(0, 0, 0, 0, 0);
    #2 nRST = 1'b0;
    #1;
    chk("rstmid_addr", m.imemaddr, 0);
    chk("rstmid_ren", m.imemREN, 0);
    next;
    nRST = 1'b1;
    drive(1, 0, 0, 0, 0);
    push(0);
    @(negedge CLK);
    chk("rstmid_en", m.ifid_EN, 1);
    next;
    chk("rstmid_next", m.imemaddr, 4);

    // halt beats a simultaneous redirect
    drive(1, 0, 1, 32'h700, 1);
    @(negedge CLK);
    chk("halt_en", m.ifid_EN, 0);
    next;
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 1, 32'h800, 0);
      @(negedge CLK);
      chk("halted_ren", m.imemREN, 0);
      chk("halted_flush", m.ifid_flush, 0);
      chk("halted_en", m.ifid_EN, 0);
      chk("halted_instr", m.ifid_instr, 0);
      chk("halted_addr", m.imemaddr, 4);
      next;
    end

    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the pipelined MIPS datapath; it is the producer side of the IF/ID pipeline register.
- Owns the PC and issues word requests to instruction memory using a REN/ihit handshake.
- Presents PC+4 and the instruction to the IF/ID latch, together with that latch's EN and flush controls.
- Handles downstream stalls by buffering one instruction, absorbs branch/jump redirects while a fetch is in flight, and stops fetching on halt.

Parameters:
- PC_INIT, 32'h0000_0000, PC value loaded on reset.
- WORD_W, 32, instruction/address width; PC increments by 4 modulo 2^WORD_W.

Ports:
- CLK  in  1  clock
- nRST  in  1  reset
- ihit  in  1  instruction memory has returned iload for imemaddr this cycle
- iload  in  WORD_W  instruction word from memory, valid when ihit=1
- imemREN  out  1  instruction read request
- imemaddr  out  WORD_W  fetch address (equals PC)
- stall  in  1  downstream (hazard unit) cannot accept a new IF/ID entry this cycle
- redirect  in  1  taken branch/jump resolved this cycle
- redirect_pc  in  WORD_W  target address, valid when redirect=1
- halt  in  1  halt decoded; stop fetching
- ifid_PC4  out  WORD_W  PC+4 of the presented instruction
- ifid_instr  out  WORD_W  presented instruction
- ifid_EN  out  1  IF/ID latch load enable
- ifid_flush  out  1  IF/ID latch clear

Behaviour:
- Reset: reset nRST, asynchronous, active-low; clock CLK.
  - Reset values: PC=PC_INIT, state=FETCH, buf=0, pend_valid=0, pend_pc=0.
  - While nRST=0: imemREN=0, ifid_EN=0, ifid_flush=0.
- States: FETCH, HOLD, HALTED.
- imemaddr = PC at all times.
- imemREN = 1 in FETCH, 0 in HOLD and HALTED.
- ifid_PC4 = PC+4 with wrap; PC=32'hFFFF_FFFC gives 0.
- ifid_instr = iload in FETCH, buf in HOLD, 0 in HALTED.
- ifid_flush = redirect, combinational, in FETCH and HOLD. Always 0 in HALTED.
- Priority per cycle: reset > halt > redirect > pending redirect > normal advance.
- halt=1 in any state:
  - Next state HALTED; ifid_EN=0 this cycle; PC unchanged; pend_valid cleared.
  - HALTED is left only by reset.
- FETCH, redirect=1:
  - If ihit=1: the returned word is discarded (ifid_EN=0), PC<=redirect_pc, pend_valid<=0.
  - If ihit=0: the in-flight address is kept stable; pend_valid<=1, pend_pc<=redirect_pc.
  - A later redirect while pending overwrites pend_pc (newest target wins).
- FETCH, pend_valid=1, ihit=1, redirect=0: the word is discarded (ifid_EN=0), PC<=pend_pc, pend_valid<=0.
- FETCH, ihit=1, no redirect or pending, stall=0: ifid_EN=1, PC<=PC+4. Latency: iload reaches IF/ID on the same edge as ihit.
- FETCH, ihit=1, no redirect or pending, stall=1: buf<=iload, next state HOLD, ifid_EN=0, PC unchanged.
- FETCH, ihit=0, no redirect: ifid_EN=0, no state change.
- HOLD, stall=1: ifid_EN=0, hold everything.
- HOLD, stall=0: ifid_EN=1 (buf enters IF/ID), PC<=PC+4, next state FETCH.
- HOLD, redirect=1: buf dropped, ifid_EN=0, PC<=redirect_pc, next state FETCH.
- ifid_EN and ifid_flush may both be 1 only when the latch resolves flush first; the block itself never asserts ifid_EN=1 while redirect=1.
- Reset mid-fetch or mid-HOLD: all state returns to reset values immediately; a pending redirect is lost.

Test Plan:
- Reset with PC_INIT=0, ihit=1 every cycle, iload=PC-derived pattern, stall=0 -> imemaddr 0,4,8,12; ifid_EN=1 each cycle; ifid_PC4 4,8,12,16.
- At PC=8, ihit=1, stall=1 for 3 cycles, then stall=0 -> state HOLD, ifid_EN=0 for 3 cycles, imemREN=0, ifid_instr=word@8; then ifid_EN=1 once and imemaddr becomes 12.
- At PC=16, ihit=0, redirect=1 with redirect_pc=0x100; ihit returns 2 cycles later -> ifid_flush=1 in the redirect cycle; imemaddr stays 16 until ihit; that word is discarded (ifid_EN=0); next imemaddr=0x100.
- Two redirects while waiting (0x200 then 0x300), then ihit -> PC becomes 0x300.
- In HOLD, redirect=1 with redirect_pc=0x40 -> buf dropped, ifid_flush=1, ifid_EN=0, state FETCH, imemaddr=0x40.
- PC_INIT=32'hFFFF_FFFC with one ihit -> ifid_PC4=0 and PC wraps to 0.
- halt=1 together with redirect=1 -> state HALTED, ifid_flush=0, imemREN=0 thereafter.
- Pulse nRST low while pending -> PC=PC_INIT, pend_valid=0.
